// File: rtl/decode_reg_pkg.sv
// decode_reg_pkg: shared RV32I decode encodings, the ID/EX control bundle and the immediate extender.
package decode_reg_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} res_src_e;
  typedef struct packed {
    logic     illegal;
    logic     reg_write;
    res_src_e res_src;
    logic     mem_write;
    logic     jump;
    logic     branch;
    alu_ctl_e alu_ctl;
    logic     alu_src;
  } ctl_t;
  localparam ctl_t CTL_NOP = '{illegal: 1'b0, reg_write: 1'b0, res_src: RES_ALU, mem_write: 1'b0,
                               jump: 1'b0, branch: 1'b0, alu_ctl: ALU_ADD, alu_src: 1'b0};
  // Every format sign-extends from instruction bit 31; B and J immediates are halfword-aligned.
  function automatic logic [XLEN-1:0] imm_ext(input logic [31:7] i, input imm_src_e s);
    return s == IMM_I ? {{20{i[31]}}, i[31:20]} :
           s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
                        {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/decode_reg_reg_file.sv
// reg_file: 2-read 1-write register file, x0 hardwired to zero, write-through bypass on reads.
module reg_file
  import decode_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic w_wr;
  assign w_wr = i_we && i_wa != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wa] <= i_wd;
    end
  assign o_rd1 = i_ra1 == '0 ? '0 : (w_wr && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = i_ra2 == '0 ? '0 : (w_wr && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
endmodule

// File: rtl/decode_reg.sv
// decode_reg: RV32I decode stage -- register file, main/ALU decode, immediate extend and the ID/EX register.
module decode_reg
  import decode_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     i_instr_d,
  input  logic [XLEN-1:0] i_pc_d,
  input  logic [XLEN-1:0] i_pc_plus4_d,
  input  logic            i_reg_write_w,
  input  logic [AW-1:0]   i_rd_w,
  input  logic [XLEN-1:0] i_result_w,
  input  logic            i_flush_e,
  output logic [AW-1:0]   o_rs1_d,
  output logic [AW-1:0]   o_rs2_d,
  output logic            o_reg_write_e,
  output logic [1:0]      o_result_src_e,
  output logic            o_mem_write_e,
  output logic            o_jump_e,
  output logic            o_branch_e,
  output logic [2:0]      o_alu_control_e,
  output logic            o_alu_src_e,
  output logic [XLEN-1:0] o_rd1_e,
  output logic [XLEN-1:0] o_rd2_e,
  output logic [XLEN-1:0] o_imm_ext_e,
  output logic [XLEN-1:0] o_pc_e,
  output logic [XLEN-1:0] o_pc_plus4_e,
  output logic [AW-1:0]   o_rs1_e,
  output logic [AW-1:0]   o_rs2_e,
  output logic [AW-1:0]   o_rd_e,
  output logic            o_illegal_e
);
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [AW-1:0] w_rd;
  logic [1:0] w_alu_op;
  logic w_f3_ok;
  logic w_ill;
  imm_src_e w_imm_src;
  ctl_t w_ctl;
  logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
  ctl_t r_ctl;
  logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pcp4;
  logic [AW-1:0] r_rs1, r_rs2, r_rd;
  assign w_op = i_instr_d[6:0];
  assign w_rd = i_instr_d[11:7];
  assign w_f3 = i_instr_d[14:12];
  assign o_rs1_d = i_instr_d[19:15];
  assign o_rs2_d = i_instr_d[24:20];
  assign w_f7 = i_instr_d[31:25];
  assign w_f3_ok = w_f3 == 3'b000 || w_f3 == 3'b010 || w_f3 == 3'b110 || w_f3 == 3'b111;
  always_comb begin
    w_ctl = CTL_NOP;
    w_imm_src = IMM_I;
    w_alu_op = 2'b00;
    w_ill = 1'b0;
    case (w_op)
      OP_LW: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_src = 1'b1;
        w_ctl.res_src = RES_MEM;
        w_ill = w_f3 != 3'b010;
      end
      OP_SW: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.alu_src = 1'b1;
        w_imm_src = IMM_S;
        w_ill = w_f3 != 3'b010;
      end
      OP_R: begin
        w_ctl.reg_write = 1'b1;
        w_alu_op = 2'b10;
        w_ill = !((w_f7 == 7'h00 && w_f3_ok) || (w_f7 == 7'h20 && w_f3 == 3'b000));
      end
      OP_I: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_src = 1'b1;
        w_alu_op = 2'b10;
        w_ill = !w_f3_ok;
      end
      OP_BEQ: begin
        w_ctl.branch = 1'b1;
        w_imm_src = IMM_B;
        w_alu_op = 2'b01;
        w_ill = w_f3 != 3'b000;
      end
      OP_JAL: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.jump = 1'b1;
        w_ctl.res_src = RES_PC4;
        w_imm_src = IMM_J;
      end
      default: w_ill = 1'b1;
    endcase
    w_ctl.alu_ctl = w_alu_op == 2'b00 ? ALU_ADD :
                    w_alu_op == 2'b01 ? ALU_SUB :
                    w_f3 == 3'b000    ? ((w_op[5] & w_f7[5]) ? ALU_SUB : ALU_ADD) :
                    w_f3 == 3'b010    ? ALU_SLT :
                    w_f3 == 3'b110    ? ALU_OR :
                    w_f3 == 3'b111    ? ALU_AND : ALU_ADD;
    // An unsupported encoding travels down the pipe as a bubble that only carries the flag.
    if (w_ill) begin
      w_ctl = CTL_NOP;
      w_ctl.illegal = 1'b1;
    end
  end
  assign w_imm = imm_ext(i_instr_d[31:7], w_imm_src);
  reg_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we  (i_reg_write_w),
    .i_wa  (i_rd_w),
    .i_wd  (i_result_w),
    .i_ra1 (o_rs1_d),
    .i_ra2 (o_rs2_d),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || i_flush_e) begin
      r_ctl <= CTL_NOP;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
      r_pc <= '0;
      r_pcp4 <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd <= '0;
    end else begin
      r_ctl <= w_ctl;
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      r_imm <= w_imm;
      r_pc <= i_pc_d;
      r_pcp4 <= i_pc_plus4_d;
      r_rs1 <= o_rs1_d;
      r_rs2 <= o_rs2_d;
      r_rd <= w_rd;
    end
  assign o_reg_write_e = r_ctl.reg_write;
  assign o_result_src_e = r_ctl.res_src;
  assign o_mem_write_e = r_ctl.mem_write;
  assign o_jump_e = r_ctl.jump;
  assign o_branch_e = r_ctl.branch;
  assign o_alu_control_e = r_ctl.alu_ctl;
  assign o_alu_src_e = r_ctl.alu_src;
  assign o_illegal_e = r_ctl.illegal;
  assign o_rd1_e = r_rd1;
  assign o_rd2_e = r_rd2;
  assign o_imm_ext_e = r_imm;
  assign o_pc_e = r_pc;
  assign o_pc_plus4_e = r_pcp4;
  assign o_rs1_e = r_rs1;
  assign o_rs2_e = r_rs2;
  assign o_rd_e = r_rd;
endmodule

// File: tb/tb_decode_reg.sv
// tb_decode_reg: scoreboard bench for decode_reg; expected ID/EX contents queued at drive time, checked one edge later.
module tb_decode_reg;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] i_instr_d, i_pc_d, i_pc_plus4_d, i_result_w;
  logic i_reg_write_w, i_flush_e;
  logic [4:0] i_rd_w;
  logic [4:0] o_rs1_d, o_rs2_d, o_rs1_e, o_rs2_e, o_rd_e;
  logic o_reg_write_e, o_mem_write_e, o_jump_e, o_branch_e, o_alu_src_e, o_illegal_e;
  logic [1:0] o_result_src_e;
  logic [2:0] o_alu_control_e;
  logic [31:0] o_rd1_e, o_rd2_e, o_imm_ext_e, o_pc_e, o_pc_plus4_e;
  always #5 clk = ~clk;
  decode_reg dut (
    .clk(clk), .rst_n(rst_n), .i_instr_d(i_instr_d), .i_pc_d(i_pc_d), .i_pc_plus4_d(i_pc_plus4_d),
    .i_reg_write_w(i_reg_write_w), .i_rd_w(i_rd_w), .i_result_w(i_result_w), .i_flush_e(i_flush_e),
    .o_rs1_d(o_rs1_d), .o_rs2_d(o_rs2_d), .o_reg_write_e(o_reg_write_e), .o_result_src_e(o_result_src_e),
    .o_mem_write_e(o_mem_write_e), .o_jump_e(o_jump_e), .o_branch_e(o_branch_e),
    .o_alu_control_e(o_alu_control_e), .o_alu_src_e(o_alu_src_e), .o_rd1_e(o_rd1_e), .o_rd2_e(o_rd2_e),
    .o_imm_ext_e(o_imm_ext_e), .o_pc_e(o_pc_e), .o_pc_plus4_e(o_pc_plus4_e), .o_rs1_e(o_rs1_e),
    .o_rs2_e(o_rs2_e), .o_rd_e(o_rd_e), .o_illegal_e(o_illegal_e)
  );
  // control bundle: {illegal, reg_write, result_src[1:0], mem_write, jump, branch, alu_ctl[2:0], alu_src}
  localparam logic [10:0] C_ADDI = 11'b0_1_00_0_0_0_000_1;
  localparam logic [10:0] C_ADD  = 11'b0_1_00_0_0_0_000_0;
  localparam logic [10:0] C_SUB  = 11'b0_1_00_0_0_0_001_0;
  localparam logic [10:0] C_OR   = 11'b0_1_00_0_0_0_011_0;
  localparam logic [10:0] C_SLTI = 11'b0_1_00_0_0_0_101_1;
  localparam logic [10:0] C_ANDI = 11'b0_1_00_0_0_0_010_1;
  localparam logic [10:0] C_BEQ  = 11'b0_0_00_0_0_1_001_0;
  localparam logic [10:0] C_SW   = 11'b0_0_00_1_0_0_000_1;
  localparam logic [10:0] C_LW   = 11'b0_1_01_0_0_0_000_1;
  localparam logic [10:0] C_JAL  = 11'b0_1_10_0_1_0_000_0;
  localparam logic [10:0] C_ILL  = 11'b1_0_00_0_0_0_000_0;
  typedef struct packed {
    logic [10:0] ctl;
    logic [31:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;
  exp_t q[$];
  logic [31:0] model [0:31];
  logic [31:0] pc_n = 32'h10;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd_ref(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    return a == 5'd0 ? 32'd0 : (we && wa == a) ? wd : model[a];
  endfunction
  function automatic logic [10:0] ctl_obs();
    return {o_illegal_e, o_reg_write_e, o_result_src_e, o_mem_write_e, o_jump_e, o_branch_e,
            o_alu_control_e, o_alu_src_e};
  endfunction
  task automatic check_e(input string tag, input exp_t e);
    chk({tag, ".ctl"}, {21'd0, ctl_obs()}, {21'd0, e.ctl});
    chk({tag, ".rd1"}, o_rd1_e, e.rd1);
    chk({tag, ".rd2"}, o_rd2_e, e.rd2);
    chk({tag, ".imm"}, o_imm_ext_e, e.imm);
    chk({tag, ".pc"}, o_pc_e, e.pc);
    chk({tag, ".pcp4"}, o_pc_plus4_e, e.pcp4);
    chk({tag, ".regs"}, {17'd0, o_rs1_e, o_rs2_e, o_rd_e}, {17'd0, e.rs1, e.rs2, e.rd});
  endtask
  task automatic issue(input string tag, input logic [31:0] instr, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic flush, input logic [10:0] ctl,
                       input logic [31:0] imm);
    exp_t e;
    @(negedge clk);
    i_instr_d = instr;
    i_pc_d = pc_n;
    i_pc_plus4_d = pc_n + 32'd4;
    i_reg_write_w = we;
    i_rd_w = wa;
    i_result_w = wd;
    i_flush_e = flush;
    e = '{ctl: ctl, rd1: rd_ref(instr[19:15], we, wa, wd), rd2: rd_ref(instr[24:20], we, wa, wd),
          imm: imm, pc: pc_n, pcp4: pc_n + 32'd4, rs1: instr[19:15], rs2: instr[24:20], rd: instr[11:7]};
    if (flush) e = '0;
    q.push_back(e);
    pc_n = pc_n + 32'd4;
    #1;
    chk({tag, ".rs_d"}, {22'd0, o_rs1_d, o_rs2_d}, {22'd0, instr[19:15], instr[24:20]});
    @(posedge clk);
    if (we && wa != 5'd0) model[wa] = wd;
    #1;
    check_e(tag, q.pop_front());
  endtask
  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b0;
    {i_instr_d, i_pc_d, i_pc_plus4_d, i_result_w, i_reg_write_w, i_rd_w, i_flush_e} = '0;
    repeat (2) @(posedge clk);
    #1 check_e("reset", '0);
    @(negedge clk) rst_n = 1'b1;
    issue("addi", 32'h00500093, 1'b1, 5'd1, 32'h11, 1'b0, C_ADDI, 32'd5);
    issue("add_byp", 32'h002101B3, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0, C_ADD, 32'd2);
    issue("x0_wr", 32'h00000233, 1'b1, 5'd0, 32'd7, 1'b0, C_ADD, 32'd0);
    issue("beq", 32'hFE208CE3, 1'b0, 5'd0, 32'd0, 1'b0, C_BEQ, 32'hFFFFFFF8);
    issue("sw", 32'h0020A423, 1'b0, 5'd0, 32'd0, 1'b0, C_SW, 32'd8);
    issue("lw_flush", 32'hFFC0A283, 1'b1, 5'd6, 32'h66, 1'b1, C_LW, 32'hFFFFFFFC);
    issue("lw", 32'hFFC0A283, 1'b0, 5'd0, 32'd0, 1'b0, C_LW, 32'hFFFFFFFC);
    issue("op7f", 32'h0000007F, 1'b0, 5'd0, 32'd0, 1'b0, C_ILL, 32'd0);
    issue("jal", 32'h010000EF, 1'b0, 5'd0, 32'd0, 1'b0, C_JAL, 32'd16);
    issue("sub", 32'h401303B3, 1'b0, 5'd0, 32'd0, 1'b0, C_SUB, 32'h401);
    issue("slti", 32'hFFF0A413, 1'b1, 5'd31, 32'h12345678, 1'b0, C_SLTI, 32'hFFFFFFFF);
    issue("bad_f7", 32'h02208233, 1'b0, 5'd0, 32'd0, 1'b0, C_ILL, 32'h22);
    issue("or", 32'h0020E4B3, 1'b0, 5'd0, 32'd0, 1'b0, C_OR, 32'd2);
    issue("andi", 32'h0F017513, 1'b0, 5'd0, 32'd0, 1'b0, C_ANDI, 32'hF0);
    i_reg_write_w = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_e("async_rst", '0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(posedge clk);
    #1 check_e("rst_hold", '0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      issue("rd_clr", {7'd0, r, r, 3'b000, 5'd0, 7'b0110011}, 1'b0, 5'd0, 32'd0, 1'b0, C_ADD, 32'(i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
